// File: rtl/riscv_fetch_queue.sv
// RV32I fetch front end: owns the PC, issues sequential word fetches and buffers {pc, instr} in a prefetch FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN: flag and halt on misaligned redirect targets instead of forcing alignment.
module riscv_fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            instr_read,
   output logic [XLEN-1:0] instr_addr,
   input  logic [XLEN-1:0] instr_out,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] fetch_instr,
   output logic            fetch_misalign
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  issue_pc_q;
   logic             inflight_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             misalign_q, misalign_d;
   logic [XLEN-1:0]  head_pc_q, head_pc_d;
   logic [XLEN-1:0]  head_instr_q, head_instr_d;
   logic [XLEN-1:0]  mem_pc    [DEPTH];
   logic [XLEN-1:0]  mem_instr [DEPTH];

   logic [XLEN-1:0]  target;
   logic             bad_target;
   logic [OCC_W-1:0] occupancy;
   logic             issue;
   logic             push;
   logic             pop;

`ifdef FETCH_ALIGN_CHECK_EN
   assign target     = redirect_pc;
   assign bad_target = (redirect_pc[1:0] != 2'b00);
`else
   assign target     = redirect_pc & ~XLEN'(3);
   assign bad_target = 1'b0;
`endif

   assign instr_read     = issue;
   assign instr_addr     = pc_q;
   assign fetch_valid    = (count_q != '0);
   assign fetch_pc       = head_pc_q;
   assign fetch_instr    = head_instr_q;
   assign fetch_misalign = misalign_q;

   // Credit counts the in-flight fetch so a response always finds a free slot.
   // A redirect kills the response arriving in its own cycle and issues nothing itself.
   always_comb begin
      occupancy    = OCC_W'(count_q) + OCC_W'(inflight_q);
      issue        = rst && !redirect_valid && !misalign_q && (occupancy < OCC_W'(DEPTH));
      push         = inflight_q && !redirect_valid;
      pop          = fetch_valid && fetch_ready && !redirect_valid;
      pc_d         = pc_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      misalign_d   = misalign_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;

      if (redirect_valid) begin
         pc_d       = target;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         misalign_d = bad_target;
      end else begin
         if (issue) begin
            pc_d = pc_q + XLEN'(4);
         end
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
      end

      // Head registers: bypass the response when it becomes the sole entry, hold when empty.
      if (count_d != '0) begin
         if (push && (count_d == CNT_W'(1))) begin
            head_pc_d    = issue_pc_q;
            head_instr_d = instr_out;
         end else begin
            head_pc_d    = mem_pc[rd_ptr_d];
            head_instr_d = mem_instr[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         issue_pc_q   <= '0;
         inflight_q   <= 1'b0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         misalign_q   <= 1'b0;
         head_pc_q    <= '0;
         head_instr_q <= '0;
      end else begin
         pc_q         <= pc_d;
         inflight_q   <= issue;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         misalign_q   <= misalign_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         if (issue) begin
            issue_pc_q <= pc_q;
         end
      end
   end

   // FIFO storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]    <= issue_pc_q;
         mem_instr[wr_ptr_q] <= instr_out;
      end
   end

endmodule
